mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues load/store requests, waits out a slow memory,
// aligns and extends load data, and registers the writeback slot with forwarding.
module mem_wb_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_exec,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_write_reg,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_fault,
    output logic [REG_AW-1:0] wb_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic              fwd_reg_write,
    output logic [REG_AW-1:0] fwd_write_reg,
    output logic [DATA_W-1:0] fwd_data
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              access;
    logic              misaligned;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] ext_by_size [4];

    logic              cap_valid;
    logic              cap_reg_write;
    logic              cap_fault;
    logic [REG_AW-1:0] cap_write_reg;
    logic [DATA_W-1:0] cap_data;

    assign access = in_valid && !flush && (in_mem_read || in_mem_write);

    // Double-word accesses on a 32-bit datapath cannot be served, so they fault.
    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = in_exec[0];
            2'b10:   misaligned = |in_exec[1:0];
            default: misaligned = (DATA_W < 64) || (|in_exec[2:0]);
        endcase
    end

    // Once in WAIT the access is committed: flush no longer affects it.
    assign mem_req   = !reset && ((state_reg == WAIT) || (access && !misaligned));
    assign stall_out = mem_req && !mem_ready;
    assign mem_we    = mem_req && in_mem_write;
    assign mem_addr  = in_exec;
    assign mem_wdata = in_store_data;
    assign mem_size  = in_size;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            localparam int W = 8 << gi;
            if (W < DATA_W) begin : g_narrow
                assign ext_by_size[gi] = {{(DATA_W - W){in_signed && mem_rdata[W-1]}},
                                          mem_rdata[W-1:0]};
            end else begin : g_full
                assign ext_by_size[gi] = mem_rdata;
            end
        end
    endgenerate

    assign load_data = ext_by_size[in_size];

    always_comb begin
        state_next = IDLE;
        if (mem_req && !mem_ready) begin
            state_next = WAIT;
        end
    end

    // Value WB will take at the next edge; doubles as the forwarding source.
    always_comb begin
        cap_valid     = 1'b0;
        cap_reg_write = 1'b0;
        cap_fault     = 1'b0;
        cap_write_reg = '0;
        cap_data      = '0;
        if (reset) begin
            cap_valid = 1'b0;
        end else if (mem_req) begin
            if (mem_ready) begin
                cap_valid     = 1'b1;
                cap_reg_write = in_reg_write;
                cap_write_reg = in_write_reg;
                cap_data      = (in_mem_read && in_mem_to_reg) ? load_data : in_exec;
            end
        end else if (in_valid && !flush) begin
            cap_valid     = 1'b1;
            cap_write_reg = in_write_reg;
            cap_data      = in_exec;
            if (access && misaligned) begin
                cap_fault = 1'b1;
            end else begin
                cap_reg_write = in_reg_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            wb_write_reg <= '0;
            wb_data      <= '0;
        end else begin
            state_reg    <= state_next;
            wb_valid     <= cap_valid;
            wb_reg_write <= cap_reg_write;
            wb_fault     <= cap_fault;
            wb_write_reg <= cap_write_reg;
            wb_data      <= cap_data;
        end
    end

    assign fwd_valid     = cap_valid;
    assign fwd_reg_write = cap_reg_write;
    assign fwd_write_reg = cap_write_reg;
    assign fwd_data      = cap_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (64-bit datapath): ALU pass-through, stalled and
// immediate loads, stores, misaligned faults, flush in IDLE/WAIT and reset in WAIT.
module tb_mem_wb_stage;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [DATA_W-1:0] in_exec, in_store_data;
    logic [REG_AW-1:0] in_write_reg;
    logic              flush;
    logic              stall_out, mem_req, mem_we;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid, wb_reg_write, wb_fault;
    logic [REG_AW-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_data;
    logic              fwd_valid, fwd_reg_write;
    logic [REG_AW-1:0] fwd_write_reg;
    logic [DATA_W-1:0] fwd_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_mem_write  (in_mem_write),
        .in_mem_read   (in_mem_read),
        .in_mem_to_reg (in_mem_to_reg),
        .in_reg_write  (in_reg_write),
        .in_size       (in_size),
        .in_signed     (in_signed),
        .in_exec       (in_exec),
        .in_store_data (in_store_data),
        .in_write_reg  (in_write_reg),
        .flush         (flush),
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_size      (mem_size),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_fault      (wb_fault),
        .wb_write_reg  (wb_write_reg),
        .wb_data       (wb_data),
        .fwd_valid     (fwd_valid),
        .fwd_reg_write (fwd_reg_write),
        .fwd_write_reg (fwd_write_reg),
        .fwd_data      (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [1:0] sz, input logic sg,
                          input logic [63:0] ex, input logic [63:0] sd, input logic [4:0] wr_reg);
        in_valid      = v;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_size       = sz;
        in_signed     = sg;
        in_exec       = ex;
        in_store_data = sd;
        in_write_reg  = wr_reg;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        set_op(1, 1, 0, 1, 1, 2'b00, 0, 64'h1000, 64'h0, 5'd1);

        // Reset: outputs forced quiet even with a pending load on the inputs
        #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_stall", {63'd0, stall_out}, 64'd0);
        step();
        step();
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        $display("txn reset");

        reset = 1'b0;
        set_op(0, 0, 0, 0, 0, 2'b00, 0, 64'h0, 64'h0, 5'd0);
        step();

        // ALU op passes straight through
        set_op(1, 0, 0, 0, 1, 2'b11, 0, 64'h1234, 64'h0, 5'd7);
        #1;
        check("alu_mem_req", {63'd0, mem_req}, 64'd0);
        check("alu_fwd_data", fwd_data, 64'h1234);
        check("alu_fwd_valid", {63'd0, fwd_valid}, 64'd1);
        step();
        check("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("alu_wb_data", wb_data, 64'h1234);
        check("alu_wb_reg", {59'd0, wb_write_reg}, 64'd7);
        check("alu_wb_rw", {63'd0, wb_reg_write}, 64'd1);
        $display("txn alu exec=0x1234 rd=7");

        // Signed byte load, memory slow for two cycles
        set_op(1, 1, 0, 1, 1, 2'b00, 1, 64'h1001, 64'h0, 5'd3);
        mem_ready = 1'b0;
        mem_rdata = 64'h80;
        #1;
        check("lb_req", {63'd0, mem_req}, 64'd1);
        check("lb_stall1", {63'd0, stall_out}, 64'd1);
        check("lb_addr", mem_addr, 64'h1001);
        check("lb_we", {63'd0, mem_we}, 64'd0);
        check("lb_fwd_valid_stall", {63'd0, fwd_valid}, 64'd0);
        step();
        check("lb_bubble_valid", {63'd0, wb_valid}, 64'd0);
        check("lb_bubble_rw", {63'd0, wb_reg_write}, 64'd0);
        check("lb_stall2", {63'd0, stall_out}, 64'd1);
        check("lb_req_wait", {63'd0, mem_req}, 64'd1);
        mem_ready = 1'b1;
        #1;
        check("lb_stall_done", {63'd0, stall_out}, 64'd0);
        check("lb_fwd_data", fwd_data, 64'hFFFF_FFFF_FFFF_FF80);
        step();
        check("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("lb_wb_reg", {59'd0, wb_write_reg}, 64'd3);
        set_op(0, 0, 0, 0, 0, 2'b00, 0, 64'h0, 64'h0, 5'd0);
        mem_ready = 1'b0;
        #1;
        check("lb_back_idle", {63'd0, mem_req}, 64'd0);
        $display("txn lb addr=0x1001 data=0xffffffffffffff80");

        // Unsigned half load, immediate completion; high rdata bits must be dropped
        set_op(1, 1, 0, 1, 1, 2'b01, 0, 64'h2002, 64'h0, 5'd4);
        mem_ready = 1'b1;
        mem_rdata = 64'h1234_5678_1234_BEEF;
        #1;
        check("lhu_req", {63'd0, mem_req}, 64'd1);
        check("lhu_stall", {63'd0, stall_out}, 64'd0);
        check("lhu_size", {62'd0, mem_size}, 64'd1);
        step();
        check("lhu_wb_data", wb_data, 64'h0000_0000_0000_BEEF);
        $display("txn lhu addr=0x2002 data=0xbeef");

        // Misaligned word store faults without a request
        set_op(1, 0, 1, 0, 1, 2'b10, 0, 64'h3002, 64'hAAAA, 5'd5);
        #1;
        check("sw_mis_req", {63'd0, mem_req}, 64'd0);
        check("sw_mis_stall", {63'd0, stall_out}, 64'd0);
        step();
        check("sw_mis_valid", {63'd0, wb_valid}, 64'd1);
        check("sw_mis_fault", {63'd0, wb_fault}, 64'd1);
        check("sw_mis_rw", {63'd0, wb_reg_write}, 64'd0);
        $display("txn sw misaligned addr=0x3002");

        // Misaligned half load also faults
        set_op(1, 1, 0, 1, 1, 2'b01, 0, 64'h2001, 64'h0, 5'd6);
        #1;
        check("lh_mis_req", {63'd0, mem_req}, 64'd0);
        step();
        check("lh_mis_fault", {63'd0, wb_fault}, 64'd1);
        $display("txn lh misaligned addr=0x2001");

        // Aligned double store: data goes out, WB gets address, rdata ignored
        set_op(1, 0, 1, 1, 0, 2'b11, 0, 64'h4008, 64'hDEAD_BEEF_CAFE_F00D, 5'd8);
        mem_rdata = 64'h5555;
        #1;
        check("sd_we", {63'd0, mem_we}, 64'd1);
        check("sd_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("sd_size", {62'd0, mem_size}, 64'd3);
        step();
        check("sd_wb_data", wb_data, 64'h4008);
        check("sd_wb_fault", {63'd0, wb_fault}, 64'd0);
        check("sd_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        $display("txn sd addr=0x4008");

        // Flush in WAIT is ignored: signed word load still completes
        set_op(1, 1, 0, 1, 1, 2'b10, 1, 64'h5004, 64'h0, 5'd9);
        mem_ready = 1'b0;
        mem_rdata = 64'h8000_0000;
        step();
        flush = 1'b1;
        #1;
        check("fw_req", {63'd0, mem_req}, 64'd1);
        check("fw_stall", {63'd0, stall_out}, 64'd1);
        mem_ready = 1'b1;
        #1;
        check("fw_stall_done", {63'd0, stall_out}, 64'd0);
        step();
        check("fw_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("fw_wb_data", wb_data, 64'hFFFF_FFFF_8000_0000);
        $display("txn lw flushed-in-wait addr=0x5004");

        // Flush in IDLE on a load kills it
        flush = 1'b1;
        set_op(1, 1, 0, 1, 1, 2'b00, 0, 64'h5100, 64'h0, 5'd10);
        #1;
        check("fi_req", {63'd0, mem_req}, 64'd0);
        step();
        check("fi_wb_valid", {63'd0, wb_valid}, 64'd0);
        flush = 1'b0;
        $display("txn lb flushed-in-idle");

        // Reset during WAIT abandons the access
        set_op(1, 1, 0, 1, 1, 2'b11, 0, 64'h6000, 64'h0, 5'd11);
        mem_ready = 1'b0;
        step();
        check("rw_in_wait", {63'd0, stall_out}, 64'd1);
        reset = 1'b1;
        #1;
        check("rw_req_low", {63'd0, mem_req}, 64'd0);
        check("rw_stall_low", {63'd0, stall_out}, 64'd0);
        step();
        reset = 1'b0;
        set_op(0, 0, 0, 0, 0, 2'b00, 0, 64'h0, 64'h0, 5'd0);
        #1;
        check("rw_idle", {63'd0, mem_req}, 64'd0);
        check("rw_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rw_wb_data", wb_data, 64'd0);
        check("rw_wb_reg", {59'd0, wb_write_reg}, 64'd0);
        $display("txn reset-in-wait");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
